alu_arbiter: RTL and testbench

- Shares the single combinational 32-bit ALU between NREQ requesters, for example the execute stage, the branch-target adder and the load/store address generator.
- Arbitrates with a round-robin scheme and drives the ALU operands and select from the granted requester.
- Captures the ALU result in a one-entry response register and returns it to the winning requester over a valid/ready handshake.
- Sits between the requesting pipeline units and the ALU instance.

---
 rtl/alu_arbiter_pkg.sv | 30 +++
 rtl/alu_arbiter_rr_picker.sv | 50 +++++
 rtl/alu_arbiter.sv | 174 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared definitions for the ALU arbiter slice:
//   - ALU_* select codes understood by the shared 32-bit ALU
//   - ALU_ARB_MAX_REQ : largest supported requester count
//   - ALU_ARB_IDXW    : width of the owner / round-robin pointer index
//   - rsp_state_e     : response register state (EMPTY / FULL)
// -----------------------------------------------------------------------------
package alu_arbiter_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam int ALU_ARB_MAX_REQ = 8;
    localparam int ALU_ARB_IDXW    = 3;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin picker. Grants the first set bit of req found
// searching upward from ptr+1, wrapping modulo NREQ.
// Ports:
//   req       in  NREQ          request vector
//   ptr       in  ALU_ARB_IDXW  index of the previous winner
//   grant     out NREQ          one-hot grant (all zero when req == 0)
//   grant_idx out ALU_ARB_IDXW  index of the granted requester
// -----------------------------------------------------------------------------
module rr_picker
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [ALU_ARB_IDXW-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [ALU_ARB_IDXW-1:0] grant_idx
);

    // Requesters strictly above the pointer get first chance; if none of
    // them is asking, the search wraps to the full vector from index 0.
    logic [NREQ-1:0] above_ptr;
    logic [NREQ-1:0] req_hi;
    logic [NREQ-1:0] search_vec;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
            assign above_ptr[gi] = (ALU_ARB_IDXW'(gi) > ptr);
        end
    endgenerate

    assign req_hi     = req & above_ptr;
    assign search_vec = (|req_hi) ? req_hi : req;

    // Lowest set bit of search_vec; scanning downward lets the lowest win.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (search_vec[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = i[ALU_ARB_IDXW-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between NREQ requesters. A grant is chosen
// combinationally, the granted operands are driven to the ALU, and the ALU
// result is captured in a one-entry response register returned to the winner
// over a valid/ready handshake.
//
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no pointer register). Undefined: round-robin.
//
// Ports:
//   I_clk, I_rstn          clock, asynchronous active-low reset
//   I_req_valid[NREQ]      request valid per requester
//   O_req_ready[NREQ]      request accepted this cycle
//   I_req_alusel[4*NREQ]   ALU select per requester (slice i = [4i+3:4i])
//   I_req_data1/2[W*NREQ]  operands per requester
//   O_alu_sel/data1/data2  drive to the shared ALU
//   I_alu_result[W]        ALU result
//   O_rsp_valid[NREQ]      one-hot response valid
//   O_rsp_data[W]          response data, shared
//   I_rsp_ready[NREQ]      response accept per requester (owner's bit used)
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 32
) (
    input  logic              I_clk,
    input  logic              I_rstn,
    input  logic [NREQ-1:0]   I_req_valid,
    output logic [NREQ-1:0]   O_req_ready,
    input  logic [4*NREQ-1:0] I_req_alusel,
    input  logic [W*NREQ-1:0] I_req_data1,
    input  logic [W*NREQ-1:0] I_req_data2,
    output logic [3:0]        O_alu_sel,
    output logic [W-1:0]      O_alu_data1,
    output logic [W-1:0]      O_alu_data2,
    input  logic [W-1:0]      I_alu_result,
    output logic [NREQ-1:0]   O_rsp_valid,
    output logic [W-1:0]      O_rsp_data,
    input  logic [NREQ-1:0]   I_rsp_ready
);

    logic [NREQ-1:0]         grant;
    logic                    grant_any;
    logic [ALU_ARB_IDXW-1:0] win_idx;
    rsp_state_e              state_reg;
    rsp_state_e              state_next;
    logic [ALU_ARB_IDXW-1:0] owner_reg;
    logic [W-1:0]            rsp_data_reg;
    logic                    owner_ready;
    logic                    accept;

    assign grant_any = |grant;

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        grant   = '0;
        win_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (I_req_valid[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                win_idx  = i[ALU_ARB_IDXW-1:0];
            end
        end
    end
`else
    logic [ALU_ARB_IDXW-1:0] ptr_reg;

    rr_picker #(
        .NREQ (NREQ)
    ) u_rr_picker (
        .req       (I_req_valid),
        .ptr       (ptr_reg),
        .grant     (grant),
        .grant_idx (win_idx)
    );

    // Reset value NREQ-1 makes requester 0 the first winner.
    always_ff @(posedge I_clk or negedge I_rstn) begin
        if (!I_rstn) begin
            ptr_reg <= ALU_ARB_IDXW'(NREQ - 1);
        end else if (accept) begin
            ptr_reg <= win_idx;
        end
    end
`endif

    // ------------------------------------------------------------------
    // ALU operand mux: ADD of zeros when idle
    // ------------------------------------------------------------------
    always_comb begin
        O_alu_sel   = ALU_ADD;
        O_alu_data1 = '0;
        O_alu_data2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                O_alu_sel   = I_req_alusel[4*i +: 4];
                O_alu_data1 = I_req_data1[W*i +: W];
                O_alu_data2 = I_req_data2[W*i +: W];
            end
        end
    end

    // Ready of the current owner; other requesters' ready bits are ignored.
    always_comb begin
        owner_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_reg == i[ALU_ARB_IDXW-1:0]) begin
                owner_ready = I_rsp_ready[i];
            end
        end
    end

    // Accept whenever the register is free or is being drained this cycle,
    // so back-to-back operations never leave a bubble.
    assign accept = grant_any &&
                    ((state_reg == RSP_EMPTY) ||
                     ((state_reg == RSP_FULL) && owner_ready));

    // ------------------------------------------------------------------
    // Response register: state register
    // ------------------------------------------------------------------
    always_ff @(posedge I_clk or negedge I_rstn) begin
        if (!I_rstn) begin
            state_reg    <= RSP_EMPTY;
            owner_reg    <= '0;
            rsp_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                owner_reg    <= win_idx;
                rsp_data_reg <= I_alu_result;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response register: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RSP_EMPTY: begin
                if (accept) state_next = RSP_FULL;
            end
            RSP_FULL: begin
                if (accept)           state_next = RSP_FULL;
                else if (owner_ready) state_next = RSP_EMPTY;
            end
            default: state_next = RSP_EMPTY;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        O_req_ready = accept ? grant : '0;
        O_rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            O_rsp_valid[i] = (state_reg == RSP_FULL) &&
                             (owner_reg == i[ALU_ARB_IDXW-1:0]);
        end
    end

    assign O_rsp_data = rsp_data_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed steps followed by a randomized phase, checked against a
// transaction-level reference model of the arbiter. The bench also plays the
// role of the shared ALU.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int NREQ = 2;
    localparam int W    = 32;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic              clk;
    logic              rstn;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_alusel;
    logic [W*NREQ-1:0] req_data1;
    logic [W*NREQ-1:0] req_data2;
    logic [3:0]        alu_sel;
    logic [W-1:0]      alu_d1;
    logic [W-1:0]      alu_d2;
    logic [W-1:0]      alu_result;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_data;
    logic [NREQ-1:0]   rsp_ready;

    // Per-requester stimulus
    logic        v [NREQ];
    logic [3:0]  s [NREQ];
    logic [31:0] a [NREQ];
    logic [31:0] b [NREQ];

    // Reference model state
    bit          m_full;
    int          m_owner;
    logic [31:0] m_data;
    int          m_last;
    bit          last_acc;
    int          last_w;

    int n_cmp = 0;
    int n_err = 0;

    alu_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .I_clk        (clk),
        .I_rstn       (rstn),
        .I_req_valid  (req_valid),
        .O_req_ready  (req_ready),
        .I_req_alusel (req_alusel),
        .I_req_data1  (req_data1),
        .I_req_data2  (req_data2),
        .O_alu_sel    (alu_sel),
        .O_alu_data1  (alu_d1),
        .O_alu_data2  (alu_d2),
        .I_alu_result (alu_result),
        .O_rsp_valid  (rsp_valid),
        .O_rsp_data   (rsp_data),
        .I_rsp_ready  (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [3:0] sel,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        case (sel)
            ALU_SUB:  return x - y;
            ALU_SLL:  return x << y[4:0];
            ALU_SLT:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (x < y) ? 32'd1 : 32'd0;
            ALU_XOR:  return x ^ y;
            ALU_SRL:  return x >> y[4:0];
            ALU_SRA:  return $unsigned($signed(x) >>> y[4:0]);
            ALU_OR:   return x | y;
            ALU_AND:  return x & y;
            default:  return x + y;
        endcase
    endfunction

    // The shared ALU itself
    always_comb alu_result = alu_f(alu_sel, alu_d1, alu_d2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]        = v[i];
            req_alusel[4*i +: 4] = s[i];
            req_data1[W*i +: W] = a[i];
            req_data2[W*i +: W] = b[i];
        end
    endtask

    task automatic model_reset();
        m_full  = 1'b0;
        m_owner = 0;
        m_data  = '0;
        m_last  = NREQ - 1;
    endtask

    // One clock cycle: drive, check combinational outputs mid-cycle against
    // the model, advance the model, check registered outputs after the edge.
    task automatic cycle();
        int w;
        bit acc;
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] exp_vld;
        drive();
        @(negedge clk);
        w = -1;
        if (FIXED) begin
            for (int k = 0; k < NREQ; k++)
                if (v[k] && w < 0) w = k;
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                int j;
                j = (m_last + k) % NREQ;
                if (v[j] && w < 0) w = j;
            end
        end
        acc = (w >= 0) && (!m_full || rsp_ready[m_owner]);
        exp_rdy = '0;
        if (acc) exp_rdy[w] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("alu_sel",   32'(alu_sel), (w >= 0) ? 32'(s[w]) : 32'(ALU_ADD));
        chk("alu_data1", alu_d1, (w >= 0) ? a[w] : 32'd0);
        chk("alu_data2", alu_d2, (w >= 0) ? b[w] : 32'd0);
        if (acc) begin
            m_full  = 1'b1;
            m_owner = w;
            m_data  = alu_f(s[w], a[w], b[w]);
            m_last  = w;
            $display("txn: req%0d sel=%0d a=%h b=%h -> %h", w, s[w], a[w], b[w], m_data);
        end else if (m_full && rsp_ready[m_owner]) begin
            m_full = 1'b0;
        end
        last_acc = acc;
        last_w   = w;
        @(posedge clk);
        #1;
        exp_vld = '0;
        if (m_full) exp_vld[m_owner] = 1'b1;
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
        chk("rsp_data",  rsp_data, m_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b0; s[i] = ALU_ADD; a[i] = '0; b[i] = '0;
        end
        rsp_ready = '0;
        rstn = 1'b1;
        drive();
        model_reset();

        // Reset state
        #1 rstn = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data",  rsp_data, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;

        // Single op: ADD 5+7, then SUB 3-5 back-to-back
        v[0] = 1'b1; s[0] = ALU_ADD; a[0] = 32'd5; b[0] = 32'd7;
        rsp_ready = 2'b01;
        cycle();
        chk("add_data",  rsp_data, 32'd12);
        chk("add_valid", 32'(rsp_valid), 32'd1);
        s[0] = ALU_SUB; a[0] = 32'd3; b[0] = 32'd5;
        cycle();
        chk("sub_data", rsp_data, 32'hFFFF_FFFE);
        v[0] = 1'b0;
        cycle();
        chk("drain_valid", 32'(rsp_valid), 32'd0);
        chk("drain_hold",  rsp_data, 32'hFFFF_FFFE);

        // Reset while FULL: outputs clear without a clock edge
        v[1] = 1'b1; s[1] = ALU_OR; a[1] = 32'hF0; b[1] = 32'h0F;
        rsp_ready = 2'b00;
        cycle();
        v[1] = 1'b0;
        drive();
        chk("full_owner1", 32'(rsp_valid), 32'd2);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_data",  rsp_data, 32'd0);
        model_reset();
        @(posedge clk); #1;
        rstn = 1'b1;

        // Round-robin from reset: 0,1,0,1
        v[0] = 1'b1; s[0] = ALU_SLL; a[0] = 32'd1;   b[0] = 32'd4;
        v[1] = 1'b1; s[1] = ALU_XOR; a[1] = 32'hF0; b[1] = 32'hFF;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("rr_data", rsp_data, (FIXED || k % 2 == 0) ? 32'd16 : 32'h0F);
        end
        v[0] = 1'b0; v[1] = 1'b0;
        cycle();

        // Backpressure: owner 0 holds off while req1 waits
        v[0] = 1'b1; s[0] = ALU_SLTU; a[0] = 32'd1; b[0] = 32'd2;
        rsp_ready = 2'b01;
        cycle();
        chk("sltu_data", rsp_data, 32'd1);
        v[0] = 1'b0;
        v[1] = 1'b1; s[1] = ALU_ADD; a[1] = 32'd100; b[1] = 32'd23;
        rsp_ready = 2'b00;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_data",  rsp_data, 32'd1);
        end
        rsp_ready = 2'b01;
        cycle();
        chk("release_valid", 32'(rsp_valid), 32'd2);
        chk("release_data",  rsp_data, 32'd123);

        // Non-owner ready is ignored
        v[1] = 1'b0;
        v[0] = 1'b1; s[0] = ALU_ADD; a[0] = 32'd1; b[0] = 32'd1;
        rsp_ready = 2'b01;
        cycle();
        chk("nonowner_valid", 32'(rsp_valid), 32'd2);
        chk("nonowner_data",  rsp_data, 32'd123);
        rsp_ready = 2'b10;
        cycle();
        chk("owner_drain_data", rsp_data, 32'd2);
        v[0] = 1'b0;
        rsp_ready = 2'b11;
        cycle();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                rsp_ready[i] = ($urandom_range(0, 3) != 0);
                if (!v[i] && $urandom_range(0, 2) != 0) begin
                    v[i] = 1'b1;
                    s[i] = 4'($urandom_range(0, 15));
                    a[i] = $urandom;
                    b[i] = $urandom;
                end
            end
            cycle();
            if (last_acc) v[last_w] = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
